// File: rtl/game_input_conditioner_if.sv
// Raw board inputs in, conditioned switch/key levels, pulses and acked events out.
// Combinational bundle only; key_ack is the consumer's only back-channel.
interface game_input_conditioner_if #(
   parameter int NUM_SW  = 16,
   parameter int NUM_KEY = 4
);
   logic [NUM_SW-1:0]  sw_raw;
   logic [NUM_KEY-1:0] key_raw;
   logic [NUM_KEY-1:0] key_ack;
   logic [NUM_SW-1:0]  sw_clean;
   logic               sw_any;
   logic               sw_change;
   logic [NUM_KEY-1:0] key_down;
   logic [NUM_KEY-1:0] key_press;
   logic [NUM_KEY-1:0] key_evt;
   logic [NUM_KEY-1:0] key_long;

   modport master (
      output sw_raw, key_raw, key_ack,
      input  sw_clean, sw_any, sw_change, key_down, key_press, key_evt, key_long
   );

   modport slave (
      input  sw_raw, key_raw, key_ack,
      output sw_clean, sw_any, sw_change, key_down, key_press, key_evt, key_long
   );
endinterface

// File: rtl/game_input_conditioner.sv
// Sync + debounce switches/keys; press pulses and sticky key events cleared by key_ack.
// Latency raw->clean 2+DB_CYCLES, no backpressure; `define KEY_LONGPRESS_EN adds long-press pulses.
module game_input_conditioner #(
   parameter int NUM_SW      = 16,
   parameter int NUM_KEY     = 4,
   parameter int DB_CYCLES   = 500000,
   parameter int CNT_W       = 20,
   parameter int LONG_CYCLES = 50000000
) (
   input  logic                      clk,
   input  logic                      rst,
   game_input_conditioner_if.slave   cond_if
);
   localparam int NB = NUM_SW + NUM_KEY;
   // Keys idle high (released), switches idle low.
   localparam logic [NB-1:0]    RST_VAL = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   if (DB_CYCLES < 2 || DB_CYCLES >= (1 << CNT_W)) begin : g_bad_db
      $error("DB_CYCLES out of range for CNT_W");
   end
   if (LONG_CYCLES < 2) begin : g_bad_long
      $error("LONG_CYCLES must be at least 2");
   end

   logic [NB-1:0]             s1_q, s2_q;
   logic [NB-1:0]             stb_q, stb_d;
   logic [NB-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic                      sw_change_q, sw_change_d;
   logic [NUM_KEY-1:0]        press_q, press_d;
   logic [NUM_KEY-1:0]        evt_q, evt_d;
   logic [NUM_KEY-1:0]        key_down, key_down_nxt;

   assign key_down = ~stb_q[NB-1:NUM_SW];

   always_comb begin
      stb_d = stb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NB; i++) begin
         if (s2_q[i] == stb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DB_LAST) begin
            stb_d[i] = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      key_down_nxt = ~stb_d[NB-1:NUM_SW];
      sw_change_d  = (stb_d[NUM_SW-1:0] != stb_q[NUM_SW-1:0]);
      press_d      = key_down_nxt & ~key_down;
      // A press landing together with an ack must survive, so set is ORed last.
      evt_d        = (evt_q & ~cond_if.key_ack) | press_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q        <= RST_VAL;
         s2_q        <= RST_VAL;
         stb_q       <= RST_VAL;
         cnt_q       <= '0;
         sw_change_q <= 1'b0;
         press_q     <= '0;
         evt_q       <= '0;
      end else begin
         s1_q        <= {cond_if.key_raw, cond_if.sw_raw};
         s2_q        <= s1_q;
         stb_q       <= stb_d;
         cnt_q       <= cnt_d;
         sw_change_q <= sw_change_d;
         press_q     <= press_d;
         evt_q       <= evt_d;
      end
   end

   assign cond_if.sw_clean  = stb_q[NUM_SW-1:0];
   assign cond_if.sw_any    = |stb_q[NUM_SW-1:0];
   assign cond_if.sw_change = sw_change_q;
   assign cond_if.key_down  = key_down;
   assign cond_if.key_press = press_q;
   assign cond_if.key_evt   = evt_q;

`ifdef KEY_LONGPRESS_EN
   localparam int            LW       = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_ARM = LW'(LONG_CYCLES - 1);

   logic [NUM_KEY-1:0][LW-1:0] hold_q, hold_d;
   logic [NUM_KEY-1:0]         long_q, long_d;

   // Counter parks at LONG_CYCLES so the arm value is seen once per hold.
   always_comb begin
      hold_d = hold_q;
      long_d = '0;
      for (int i = 0; i < NUM_KEY; i++) begin
         long_d[i] = key_down[i] && (hold_q[i] == LONG_ARM);
         if (!key_down[i]) begin
            hold_d[i] = '0;
         end else if (hold_q[i] != LONG_MAX) begin
            hold_d[i] = hold_q[i] + LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_q <= '0;
         long_q <= '0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign cond_if.key_long = long_q;
`else
   assign cond_if.key_long = '0;
`endif
endmodule

// File: tb/tb_game_input_conditioner.sv
// Directed bench with a windowed-history reference model checked every cycle.
module tb_game_input_conditioner;
   localparam int NUM_SW  = 16;
   localparam int NUM_KEY = 4;
   localparam int DB      = 4;
   localparam int CNT_W   = 20;
   localparam int LONG    = 10;
   localparam int NB      = NUM_SW + NUM_KEY;
   localparam logic [NB-1:0] RST_VAL = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   game_input_conditioner_if #(.NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY)) cif ();

   game_input_conditioner #(
      .NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY), .DB_CYCLES(DB),
      .CNT_W(CNT_W), .LONG_CYCLES(LONG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cond_if(cif)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: an input is accepted once its synchronized copy has
   // disagreed with the accepted value for DB consecutive post-reset cycles.
   logic [NB-1:0]      m_stb;
   logic [NUM_SW-1:0]  m_sw;
   logic               m_chg;
   logic [NUM_KEY-1:0] m_down, m_press, m_evt, m_long;
   int                 run [NUM_KEY];
   logic [NB-1:0]      rawq [$];
   logic [NB-1:0]      s2q  [$];
   bit                 started = 0;

   always @(posedge clk) begin : model
      logic [NB-1:0]      s2;
      logic [NUM_SW-1:0]  new_sw;
      logic [NUM_KEY-1:0] new_down;
      bit                 all_diff;
      started = 1;
      if (!rst) begin
         m_stb  = RST_VAL;
         m_sw   = '0;
         m_chg  = 1'b0;
         m_down = '0;
         m_press = '0;
         m_evt  = '0;
         m_long = '0;
         for (int i = 0; i < NUM_KEY; i++) run[i] = 0;
         rawq = {RST_VAL, RST_VAL};
         s2q.delete();
      end else begin
         s2 = rawq[0];
         rawq.push_back({cif.key_raw, cif.sw_raw});
         void'(rawq.pop_front());
         s2q.push_back(s2);
         if (s2q.size() > DB) void'(s2q.pop_front());
         if (s2q.size() == DB) begin
            for (int b = 0; b < NB; b++) begin
               all_diff = 1;
               foreach (s2q[k]) if (s2q[k][b] == m_stb[b]) all_diff = 0;
               if (all_diff) m_stb[b] = ~m_stb[b];
            end
         end
         new_sw   = m_stb[NUM_SW-1:0];
         new_down = ~m_stb[NB-1:NUM_SW];
         m_evt    = (m_evt & ~cif.key_ack) | m_press;
         for (int i = 0; i < NUM_KEY; i++) begin
            if (m_down[i]) run[i] = (run[i] > 1000) ? run[i] : run[i] + 1;
            else           run[i] = 0;
`ifdef KEY_LONGPRESS_EN
            m_long[i] = (run[i] == LONG);
`else
            m_long[i] = 1'b0;
`endif
         end
         m_press = new_down & ~m_down;
         m_chg   = (new_sw != m_sw);
         m_sw    = new_sw;
         m_down  = new_down;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("sw_clean",  cif.sw_clean,  m_sw);
         check("sw_any",    cif.sw_any,    |m_sw);
         check("sw_change", cif.sw_change, m_chg);
         check("key_down",  cif.key_down,  m_down);
         check("key_press", cif.key_press, m_press);
         check("key_evt",   cif.key_evt,   m_evt);
         check("key_long",  cif.key_long,  m_long);
      end
   end

   initial begin
      int rise, lpos, nlong;
      cif.sw_raw  = 16'h0044;
      cif.key_raw = 4'hF;
      cif.key_ack = 4'h0;
      rst = 1'b0;

      // Reset, then switches accepted 6 cycles after release.
      step(3);
      check("rst_sw_clean", cif.sw_clean, 16'h0);
      check("rst_key_down", cif.key_down, 4'h0);
      check("rst_sw_any",   cif.sw_any,   1'b0);
      rst = 1'b1;
      step(5);
      check("sw_pre_accept", cif.sw_clean, 16'h0);
      step(1);
      check("sw_accept",     cif.sw_clean,  16'h0044);
      check("sw_chg_pulse",  cif.sw_change, 1'b1);
      check("sw_any_set",    cif.sw_any,    1'b1);
      step(1);
      check("sw_chg_single", cif.sw_change, 1'b0);
      step(4);

      // Bouncing key 1, then settle pressed.
      for (int k = 0; k < 10; k++) begin
         cif.key_raw[1] = k[0];
         step(2);
      end
      cif.key_raw[1] = 1'b0;
      step(5);
      check("k1_pre_down", cif.key_down, 4'b0000);
      step(1);
      check("k1_down",  cif.key_down,  4'b0010);
      check("k1_press", cif.key_press, 4'b0010);
      step(1);
      check("k1_press_single", cif.key_press, 4'b0000);
      check("k1_evt",          cif.key_evt,   4'b0010);
      cif.key_ack = 4'b0010;
      step(1);
      cif.key_ack = 4'b0000;
      check("k1_evt_ack", cif.key_evt, 4'b0000);
      cif.key_raw[1] = 1'b1;
      step(8);

      // Key 2 pressed twice without ack collapses into one event.
      cif.key_raw[2] = 1'b0; step(8);
      cif.key_raw[2] = 1'b1; step(8);
      cif.key_raw[2] = 1'b0; step(8);
      check("k2_evt_twice", cif.key_evt, 4'b0100);
      cif.key_raw[2] = 1'b1; step(8);
      check("k2_evt_held", cif.key_evt, 4'b0100);
      cif.key_ack = 4'b0100;
      step(1);
      cif.key_ack = 4'b0000;
      check("k2_evt_ack", cif.key_evt, 4'b0000);

      // Ack coincident with press on key 3: set wins; a held ack then clears.
      cif.key_raw[3] = 1'b0;
      step(6);
      check("k3_press", cif.key_press, 4'b1000);
      cif.key_ack = 4'b1000;
      step(1);
      check("k3_set_wins", cif.key_evt, 4'b1000);
      step(3);
      check("k3_held_ack_clears", cif.key_evt, 4'b0000);
      cif.key_ack = 4'b0000;
      cif.key_raw[3] = 1'b1;
      step(8);

      // Three-cycle switch glitch is rejected.
      cif.sw_raw = 16'h0045;
      step(3);
      cif.sw_raw = 16'h0044;
      for (int k = 0; k < 10; k++) begin
         step(1);
         check("glitch_sw_clean", cif.sw_clean,  16'h0044);
         check("glitch_no_chg",   cif.sw_change, 1'b0);
      end

      // Several switch bits changing together give one pulse.
      cif.sw_raw = 16'h0003;
      step(5);
      check("multi_pre", cif.sw_change, 1'b0);
      step(1);
      check("multi_clean", cif.sw_clean,  16'h0003);
      check("multi_chg",   cif.sw_change, 1'b1);
      step(1);
      check("multi_chg_single", cif.sw_change, 1'b0);
      cif.sw_raw = 16'h0000;
      step(6);
      check("sw_any_clear", cif.sw_any, 1'b0);

      // Long hold on key 0.
      rise = -1; lpos = -1; nlong = 0;
      cif.key_raw[0] = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         step(1);
         if (cif.key_down[0] && rise < 0) rise = c;
         if (cif.key_long[0] === 1'b1) begin
            nlong++;
            lpos = c;
         end
      end
      cif.key_raw[0] = 1'b1;
      check("k0_down_rise", rise, 6);
`ifdef KEY_LONGPRESS_EN
      check("long_count",  nlong, 1);
      check("long_offset", lpos - rise, 10);
`else
      check("long_count",  nlong, 0);
`endif
      step(10);
      cif.key_ack = 4'b0001;
      step(1);
      cif.key_ack = 4'b0000;

      // Reset mid-count discards the partial debounce progress.
      cif.sw_raw = 16'h0100;
      step(3);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      step(5);
      check("rst_mid_pre", cif.sw_clean, 16'h0000);
      step(1);
      check("rst_mid_accept", cif.sw_clean, 16'h0100);
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
